// File: rtl/alu_mc_if.sv
// Handshake bus for the multi-cycle ALU: operand channel in, result channel out.
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [2:0]       nzp;
    logic             busy;

    // Upstream/downstream side driving operands and taking results
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, res, nzp, busy
    );

    // ALU side
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, res, nzp, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/shift ops plus an
// iterative shift-add multiplier, with valid/ready on both sides.
module alu_mc #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter bit MUL_EN  = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_LSHF  = 3'b100;
    localparam logic [2:0] OP_RSHFL = 3'b101;
    localparam logic [2:0] OP_RSHFA = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   res_q;
    logic [2:0]         nzp_q;

    logic               accept;
    logic               is_mul;
    logic [WIDTH-1:0]   alu_out;
    logic [WIDTH-1:0]   acc_next;
    logic [SHAMT_W-1:0] shamt;

    // N for negative, Z for zero, P for anything else; exactly one bit set
    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        logic zero;
        zero = (v == '0);
        return {v[WIDTH-1], zero, ~v[WIDTH-1] & ~zero};
    endfunction

    // In DONE the next operand can only be taken when the current result leaves
    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == MUL);
    assign bus.res       = res_q;
    assign bus.nzp       = nzp_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign is_mul = MUL_EN && (bus.op == OP_MUL);
    assign shamt  = bus.b[SHAMT_W-1:0];

    // Single-cycle result; MUL falls through to PASSA when the multiplier is not built
    always_comb begin
        alu_out = bus.a;
        case (bus.op)
            OP_ADD:   alu_out = bus.a + bus.b;
            OP_AND:   alu_out = bus.a & bus.b;
            OP_XOR:   alu_out = bus.a ^ bus.b;
            OP_PASSA: alu_out = bus.a;
            OP_LSHF:  alu_out = bus.a << shamt;
            OP_RSHFL: alu_out = bus.a >> shamt;
            OP_RSHFA: alu_out = WIDTH'($signed(bus.a) >>> shamt);
            default:  alu_out = bus.a;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Control FSM and datapath registers; reset drops any multiply in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            res_q  <= '0;
            nzp_q  <= 3'b000;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state  <= MUL;
                            mcand  <= bus.a;
                            mplier <= bus.b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            state <= DONE;
                            res_q <= alu_out;
                            nzp_q <= nzp_of(alu_out);
                        end
                    end else if (state == DONE && bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                        res_q <= acc_next;
                        nzp_q <= nzp_of(acc_next);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: hand-computed vectors, checked 1 time unit after each rising edge.
module tb_alu_mc;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_mc_if #(.WIDTH(16)) bus ();

    alu_mc #(.WIDTH(16), .SHAMT_W(4), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = v;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'b000, 16'h0, 16'h0);
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_res",       32'(bus.res),       32'h0);
        chk("rst_nzp",       32'(bus.nzp),       32'b000);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;
        step();

        // ADD overflow into the sign bit
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b000, 16'h7FFF, 16'h0001);
        step();
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_res",   32'(bus.res),       32'h8000);
        chk("add_nzp",   32'(bus.nzp),       32'b100);

        // Arithmetic vs logical right shift, back-to-back
        drive(1'b1, 3'b110, 16'h8010, 16'd4);
        step();
        chk("rshfa_res", 32'(bus.res), 32'hF801);
        chk("rshfa_nzp", 32'(bus.nzp), 32'b100);
        drive(1'b1, 3'b101, 16'h8010, 16'd4);
        step();
        chk("rshfl_res", 32'(bus.res), 32'h0801);
        chk("rshfl_nzp", 32'(bus.nzp), 32'b001);
        drive(1'b0, 3'b000, 16'h0, 16'h0);
        step();
        chk("idle_after_drain", 32'(bus.out_valid), 32'd0);

        // MUL 300*300 = 0x15F90 -> low half 0x5F90
        drive(1'b1, 3'b111, 16'd300, 16'd300);
        step();
        drive(1'b0, 3'b000, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            chk($sformatf("mul_busy_%0d", i),  32'(bus.busy),      32'd1);
            chk($sformatf("mul_rdy_%0d", i),   32'(bus.in_ready),  32'd0);
            chk($sformatf("mul_vld_%0d", i),   32'(bus.out_valid), 32'd0);
        end
        step();
        chk("mul_valid", 32'(bus.out_valid), 32'd1);
        chk("mul_res",   32'(bus.res),       32'h5F90);
        chk("mul_nzp",   32'(bus.nzp),       32'b001);
        chk("mul_busy",  32'(bus.busy),      32'd0);
        step();
        chk("mul_drain", 32'(bus.out_valid), 32'd0);

        // Stall: XOR to zero held while out_ready=0, new offer ignored
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b010, 16'h1234, 16'h1234);
        step();
        drive(1'b1, 3'b000, 16'h0005, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_res_%0d", i), 32'(bus.res),       32'h0);
            chk($sformatf("stall_nzp_%0d", i), 32'(bus.nzp),       32'b010);
            chk($sformatf("stall_vld_%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall_rdy_%0d", i), 32'(bus.in_ready),  32'd0);
            step();
        end
        drive(1'b0, 3'b000, 16'h0, 16'h0);
        bus.out_ready = 1'b1;
        step();
        chk("stall_drain", 32'(bus.out_valid), 32'd0);

        // Back-to-back stream: AND, PASSA, shift-by-0, shift-by-15, ADD wrap to zero
        drive(1'b1, 3'b001, 16'hF0F0, 16'hFF00);
        step();
        chk("and_res", 32'(bus.res),      32'hF000);
        chk("and_nzp", 32'(bus.nzp),      32'b100);
        chk("and_rdy", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 3'b011, 16'h0005, 16'hAAAA);
        step();
        chk("pass_res", 32'(bus.res),      32'h0005);
        chk("pass_nzp", 32'(bus.nzp),      32'b001);
        chk("pass_rdy", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 3'b100, 16'h1234, 16'hFFF0);
        step();
        chk("lshf0_res", 32'(bus.res), 32'h1234);
        drive(1'b1, 3'b100, 16'h0001, 16'h000F);
        step();
        chk("lshf15_res", 32'(bus.res), 32'h8000);
        drive(1'b1, 3'b000, 16'hFFFF, 16'h0001);
        step();
        chk("addwrap_res", 32'(bus.res), 32'h0000);
        chk("addwrap_nzp", 32'(bus.nzp), 32'b010);
        drive(1'b1, 3'b010, 16'h00FF, 16'h0F0F);
        step();
        chk("xor_res", 32'(bus.res), 32'h0FF0);
        drive(1'b0, 3'b000, 16'h0, 16'h0);
        step();

        // Reset in the middle of a multiply discards it
        drive(1'b1, 3'b111, 16'd3, 16'd5);
        step();
        drive(1'b0, 3'b000, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) step();
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_vld",  32'(bus.out_valid), 32'd0);
        chk("mrst_res",  32'(bus.res),       32'h0);
        chk("mrst_nzp",  32'(bus.nzp),       32'b000);
        chk("mrst_busy", 32'(bus.busy),      32'd0);
        chk("mrst_rdy",  32'(bus.in_ready),  32'd1);
        drive(1'b1, 3'b000, 16'd2, 16'd3);
        step();
        drive(1'b0, 3'b000, 16'h0, 16'h0);
        chk("post_add_vld", 32'(bus.out_valid), 32'd1);
        chk("post_add_res", 32'(bus.res),       32'd5);
        chk("post_add_nzp", 32'(bus.nzp),       32'b001);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
